// File: rtl/jtag_shift_engine.sv
// Command-level JTAG sequencer: TAP reset, IR/DR scan and idle clocking, paced at 2*CLK_DIV ps7_clk per TCK.
// Define JTAG_TRST_PULSE_EN to also pulse trst_no low during a TAP reset command.
module jtag_shift_engine #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        ps7_clk,
    input  logic        ps7_rst_n,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_type_i,
    input  logic [4:0]  cmd_len_i,
    input  logic [31:0] cmd_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        busy_o,
    output logic        tck_o,
    output logic        tms_o,
    output logic        tdi_o,
    output logic        trst_no,
    input  logic        tdo_i
);

    typedef enum logic [1:0] {CMD_RST = 2'b00, CMD_IR = 2'b01, CMD_DR = 2'b10, CMD_IDLE = 2'b11} cmd_e;
    typedef enum logic [2:0] {IDLE, HEAD, SHIFT, TAIL, DONE} state_e;

    state_e      state;
    state_e      adv_state;
    state_e      start_state;
    cmd_e        typ;
    logic [4:0]  len;
    logic [31:0] data;
    logic [4:0]  cnt;
    logic [4:0]  adv_cnt;
    logic [4:0]  head_last;
    logic [7:0]  div_cnt;

    // TAP pin values for a given bit position: {trst_n, tms, tdi}.
    function automatic logic [2:0] drive(input state_e st, input logic [4:0] c, input cmd_e t,
                                         input logic [4:0] l, input logic [31:0] d);
        logic       tms;
        logic       tdi;
        logic       trst_n;
        logic [7:0] pat;
        tms    = 1'b0;
        tdi    = 1'b0;
        trst_n = 1'b1;
        case (t)
            CMD_RST: pat = 8'b0001_1111;
            CMD_IR:  pat = 8'b0000_0011;
            CMD_DR:  pat = 8'b0000_0001;
            default: pat = '0;
        endcase
        case (st)
            HEAD: begin
                tms = pat[c[2:0]];
`ifdef JTAG_TRST_PULSE_EN
                trst_n = !((t == CMD_RST) && (c < 5'd5));
`endif
            end
            SHIFT: begin
                tdi = d[c];
                tms = (t != CMD_IDLE) && (c == l);
            end
            TAIL:    tms = (c == 5'd0);
            default: tms = 1'b0;
        endcase
        return {trst_n, tms, tdi};
    endfunction

    always_comb begin
        start_state = (cmd_e'(cmd_type_i) == CMD_IDLE) ? SHIFT : HEAD;
        case (typ)
            CMD_RST: head_last = 5'd5;
            CMD_IR:  head_last = 5'd3;
            default: head_last = 5'd2;
        endcase
        adv_state = state;
        adv_cnt   = cnt + 5'd1;
        case (state)
            HEAD: if (cnt == head_last) begin
                adv_cnt   = '0;
                adv_state = (typ == CMD_RST) ? DONE : SHIFT;
            end
            SHIFT: if (cnt == len) begin
                adv_cnt   = '0;
                adv_state = (typ == CMD_IDLE) ? DONE : TAIL;
            end
            TAIL: if (cnt == 5'd1) begin
                adv_cnt   = '0;
                adv_state = DONE;
            end
            default: adv_cnt = '0;
        endcase
    end

    always_ff @(posedge ps7_clk or negedge ps7_rst_n) begin
        if (!ps7_rst_n) begin
            state       <= IDLE;
            typ         <= CMD_RST;
            len         <= '0;
            data        <= '0;
            cnt         <= '0;
            div_cnt     <= '0;
            cmd_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            busy_o      <= 1'b0;
            tck_o       <= 1'b0;
            tms_o       <= 1'b0;
            tdi_o       <= 1'b0;
            trst_no     <= 1'b1;
        end else begin
            case (state)
                IDLE: if (cmd_valid_i) begin
                    typ         <= cmd_e'(cmd_type_i);
                    len         <= cmd_len_i;
                    data        <= cmd_data_i;
                    rsp_data_o  <= '0;
                    state       <= start_state;
                    cnt         <= '0;
                    div_cnt     <= '0;
                    tck_o       <= 1'b0;
                    busy_o      <= 1'b1;
                    cmd_ready_o <= 1'b0;
                    {trst_no, tms_o, tdi_o} <= drive(start_state, 5'd0, cmd_e'(cmd_type_i),
                                                     cmd_len_i, cmd_data_i);
                end
                HEAD, SHIFT, TAIL: begin
                    if (div_cnt == 8'(CLK_DIV - 1)) begin
                        div_cnt <= '0;
                        if (!tck_o) begin
                            tck_o <= 1'b1;
                            if (state == SHIFT && (typ == CMD_IR || typ == CMD_DR))
                                rsp_data_o[cnt] <= tdo_i;
                        end else begin
                            // End of the high phase: step to the next bit and present its TMS/TDI.
                            tck_o <= 1'b0;
                            state <= adv_state;
                            cnt   <= adv_cnt;
                            {trst_no, tms_o, tdi_o} <= drive(adv_state, adv_cnt, typ, len, data);
                            if (adv_state == DONE)
                                rsp_valid_o <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                DONE: if (rsp_ready_i) begin
                    state       <= IDLE;
                    rsp_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                    cmd_ready_o <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Directed bench for jtag_shift_engine: a behavioural TAP model on the pins, a response
// scoreboard checked by a separate monitor, and per-command TMS/TDI/timing checks.
`timescale 1ns/1ps
module tb_jtag_shift_engine;

    localparam int unsigned CLK_DIV = 4;

    logic        ps7_clk = 1'b0;
    logic        ps7_rst_n = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [1:0]  cmd_type_i = '0;
    logic [4:0]  cmd_len_i = '0;
    logic [31:0] cmd_data_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_data_o;
    logic        busy_o;
    logic        tck_o;
    logic        tms_o;
    logic        tdi_o;
    logic        trst_no;
    logic        tdo_i;

    jtag_shift_engine #(.CLK_DIV(CLK_DIV)) dut (
        .ps7_clk     (ps7_clk),
        .ps7_rst_n   (ps7_rst_n),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_type_i  (cmd_type_i),
        .cmd_len_i   (cmd_len_i),
        .cmd_data_i  (cmd_data_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .busy_o      (busy_o),
        .tck_o       (tck_o),
        .tms_o       (tms_o),
        .tdi_o       (tdi_o),
        .trst_no     (trst_no),
        .tdo_i       (tdo_i)
    );

    always #5 ps7_clk = ~ps7_clk;

    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    int          trst_low = 0;
    logic [31:0] sb_q[$];
    bit          tms_q[$];
    bit          tdi_q[$];

    typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                              SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_e;
    tap_e       tap = RTI;
    logic       lb = 1'b0;
    logic [1:0] tdo_mode = 2'd0;   // 0: one-bit loopback in Shift-DR, 1: tied 1, 2: tied 0

    assign tdo_i = (tdo_mode == 2'd0) ? lb : tdo_mode[0];

    function automatic tap_e tap_next(input tap_e s, input logic m);
        case (s)
            TLR:     return m ? TLR   : RTI;
            RTI:     return m ? SELDR : RTI;
            SELDR:   return m ? SELIR : CAPDR;
            CAPDR:   return m ? EX1DR : SHDR;
            SHDR:    return m ? EX1DR : SHDR;
            EX1DR:   return m ? UPDR  : PADR;
            PADR:    return m ? EX2DR : PADR;
            EX2DR:   return m ? UPDR  : SHDR;
            UPDR:    return m ? SELDR : RTI;
            SELIR:   return m ? TLR   : CAPIR;
            CAPIR:   return m ? EX1IR : SHIR;
            SHIR:    return m ? EX1IR : SHIR;
            EX1IR:   return m ? UPIR  : PAIR;
            PAIR:    return m ? EX2IR : PAIR;
            EX2IR:   return m ? UPIR  : SHIR;
            default: return m ? SELDR : RTI;
        endcase
    endfunction

    always @(posedge tck_o or negedge trst_no) begin
        if (!trst_no) begin
            tap <= TLR;
        end else begin
            if (tap == SHDR)
                lb <= tdi_o;
            else if (tap == CAPDR)
                lb <= 1'b0;
            tap <= tap_next(tap, tms_o);
            tms_q.push_back(tms_o);
            tdi_q.push_back(tdi_o);
        end
    end

    always @(posedge ps7_clk) cyc++;
    always @(negedge ps7_clk) if (!trst_no) trst_low++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every consumed response against the scoreboard.
    always @(negedge ps7_clk) begin
        if (rsp_valid_o && rsp_ready_i) begin
            if (sb_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL rsp_unexpected: got 0x%0h with empty scoreboard", rsp_data_o);
            end else begin
                check("rsp_data", {32'd0, rsp_data_o}, {32'd0, sb_q.pop_front()});
            end
        end
    end

    task automatic issue(input logic [1:0] typ, input logic [4:0] len, input logic [31:0] dat,
                         output int acc);
        int budget;
        cmd_type_i  = typ;
        cmd_len_i   = len;
        cmd_data_i  = dat;
        cmd_valid_i = 1'b1;
        budget = 0;
        while (!cmd_ready_o && budget < 2000) begin
            @(posedge ps7_clk); #1;
            budget++;
        end
        @(posedge ps7_clk); #1;
        acc = cyc;
        cmd_valid_i = 1'b0;
        cmd_type_i  = ~typ;
        cmd_len_i   = ~len;
        cmd_data_i  = ~dat;
        tms_q.delete();
        tdi_q.delete();
        trst_low = 0;
    endtask

    task automatic run_cmd(input string nm, input logic [1:0] typ, input logic [4:0] len,
                           input logic [31:0] dat, input logic [31:0] exp_rsp,
                           input int exp_tcks, input logic [63:0] exp_tms,
                           input int tdi_off, input int hold);
        int          acc;
        int          budget;
        logic [63:0] tv;
        logic [31:0] dv;
        logic [31:0] snap;
        logic        stable;
        sb_q.push_back(exp_rsp);
        issue(typ, len, dat, acc);
        check({nm, " busy/ready after accept"}, {62'd0, busy_o, cmd_ready_o}, 64'h2);
        budget = 0;
        while (!rsp_valid_o && budget < 4000) begin
            @(posedge ps7_clk); #1;
            budget++;
        end
        check({nm, " rsp_valid"}, {63'd0, rsp_valid_o}, 64'd1);
        check({nm, " latency"}, 64'(cyc - acc), 64'(2 * CLK_DIV * exp_tcks));
        check({nm, " tck count"}, 64'(tms_q.size()), 64'(exp_tcks));
        tv = '0;
        foreach (tms_q[k]) if (k < 64) tv[k] = tms_q[k];
        check({nm, " tms sequence"}, tv, exp_tms);
        check({nm, " tck/tms/tdi idle at done"}, {61'd0, tck_o, tms_o, tdi_o}, 64'd0);
        check({nm, " tap state"}, {60'd0, tap}, {60'd0, RTI});
        if (tdi_off >= 0) begin
            dv = '0;
            for (int k = 0; k <= int'(len); k++) dv[k] = tdi_q[tdi_off + k];
            check({nm, " tdi stream"}, {32'd0, dv}, {32'd0, dat});
        end
        if (hold > 0) begin
            snap   = rsp_data_o;
            stable = 1'b1;
            repeat (hold) begin
                @(posedge ps7_clk); #1;
                if (!rsp_valid_o || rsp_data_o !== snap || cmd_ready_o) stable = 1'b0;
            end
            check({nm, " held response stable"}, {63'd0, stable}, 64'd1);
        end
        rsp_ready_i = 1'b1;
        @(posedge ps7_clk); #1;
        rsp_ready_i = 1'b0;
        check({nm, " ready after consume"}, {61'd0, cmd_ready_o, rsp_valid_o, busy_o}, 64'h4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int budget;
        int exp_trst;
`ifdef JTAG_TRST_PULSE_EN
        exp_trst = 40;
`else
        exp_trst = 0;
`endif
        #12;
        check("reset outputs", {57'd0, cmd_ready_o, rsp_valid_o, busy_o, tck_o, tms_o, tdi_o, trst_no},
              64'h41);
        check("reset rsp_data", {32'd0, rsp_data_o}, 64'd0);
        @(posedge ps7_clk); #1;
        ps7_rst_n = 1'b1;
        @(posedge ps7_clk); #1;

        run_cmd("tap_reset", 2'b00, 5'd7, 32'hDEAD_BEEF, 32'h0, 6, 64'h1F, -1, 0);
        check("tap_reset trst low cycles", 64'(trst_low), 64'(exp_trst));

        tdo_mode = 2'd0;
        run_cmd("dr32_loop", 2'b10, 5'd31, 32'hA5A5_0F0F, 32'h4B4A_1E1E, 37,
                64'h0000_000C_0000_0001, 3, 0);

        tdo_mode = 2'd1;
        run_cmd("ir5_ones", 2'b01, 5'd4, 32'h0000_001F, 32'h0000_001F, 11, 64'h303, 4, 100);

        run_cmd("idle10", 2'b11, 5'd9, 32'hFFFF_FFFF, 32'h0, 10, 64'h0, -1, 0);

        run_cmd("dr1_ones", 2'b10, 5'd0, 32'h0000_0001, 32'h0000_0001, 6, 64'h19, 3, 0);

        tdo_mode = 2'd0;
        run_cmd("dr8_loop", 2'b10, 5'd7, 32'h0000_00C3, 32'h0000_0086, 13, 64'hC01, 3, 0);

        // Reset mid-SHIFT of a DR scan; the partial response is dropped.
        issue(2'b10, 5'd31, 32'hA5A5_0F0F, acc);
        budget = 0;
        while (tms_q.size() < 6 && budget < 2000) begin
            @(posedge ps7_clk); #1;
            budget++;
        end
        check("midreset reached shift", {63'd0, busy_o}, 64'd1);
        #2;
        ps7_rst_n = 1'b0;
        #1;
        check("midreset outputs", {57'd0, cmd_ready_o, rsp_valid_o, busy_o, tck_o, tms_o, tdi_o, trst_no},
              64'h41);
        check("midreset rsp_data", {32'd0, rsp_data_o}, 64'd0);
        repeat (3) @(posedge ps7_clk);
        #1;
        ps7_rst_n = 1'b1;
        @(posedge ps7_clk); #1;

        run_cmd("tap_reset_after", 2'b00, 5'd0, 32'h0, 32'h0, 6, 64'h1F, -1, 0);
        check("tap_reset_after trst low cycles", 64'(trst_low), 64'(exp_trst));

        repeat (5) @(posedge ps7_clk);
        #1;
        check("scoreboard drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
